// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the MMU memory-port arbiter.
//
// Contents:
//   LINE_W       - cache line / memory bus data width in bits
//   arb_state_t  - 3-bit arbiter state encoding
//   REQ_*        - requester IDs, used as bit positions of the one-hot grant
package mem_port_arbiter_pkg;

    localparam int LINE_W = 128;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EVICT   = 3'd1,
        DC_FILL = 3'd2,
        IO_XFER = 3'd3,
        IC_FILL = 3'd4,
        RELEASE = 3'd5
    } arb_state_t;

    localparam int REQ_DC  = 0;
    localparam int REQ_IO  = 1;
    localparam int REQ_IC  = 2;
    localparam int NUM_REQ = 3;

endpackage

// File: rtl/mem_port_prio_sel.sv
// Combinational priority selector for the memory-port arbiter.
//
// Ports:
//   dc_req    in   D-cache miss request
//   io_req    in   uncached IO request
//   ic_req    in   I-cache miss request
//   burst_sat in   D-side burst counter has reached its limit
//   grant     out  one-hot grant, bit positions are the REQ_* IDs (all zero when idle)
module mem_port_prio_sel (
    input  logic                                     dc_req,
    input  logic                                     io_req,
    input  logic                                     ic_req,
    input  logic                                     burst_sat,
    output logic [mem_port_arbiter_pkg::NUM_REQ-1:0] grant
);
    import mem_port_arbiter_pkg::*;

    // Normal order is D-cache, then IO, then I-cache. Once the D side has
    // won enough back-to-back rounds while the I-cache waits, the I-cache
    // jumps to the front so instruction fetch cannot be starved.
    always_comb begin
        grant = '0;
        if (ic_req && burst_sat) begin
            grant[REQ_IC] = 1'b1;
        end else if (dc_req) begin
            grant[REQ_DC] = 1'b1;
        end else if (io_req) begin
            grant[REQ_IO] = 1'b1;
        end else if (ic_req) begin
            grant[REQ_IC] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-owner controller for the MMU memory port.
//
// Shares one 128-bit request/ack memory bus between the I-cache line fill,
// the D-cache miss (with optional dirty-victim writeback, always issued
// before the fill) and the D-cache uncached IO path.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ic_miss / ic_miss_addr      I-cache fill request (level) and line address
//   ic_miss_ack / ic_data_fill  one-cycle ack with the fill line
//   dc_miss / dc_miss_addr      D-cache fill request (level) and line address
//   dc_evict / dc_evict_addr /
//   dc_evict_data               dirty victim to write back before the fill
//   dc_miss_ack / dc_data_fill  one-cycle ack with the fill line
//   io_access / io_rw /
//   io_addr / io_wr_data        uncached access request (level)
//   io_ack / io_rd_data         one-cycle ack, read data on reads
//   mem_req/we/io/addr/wdata    registered bus request, held until mem_ack
//   mem_rdata / mem_ack         bus read data and one-cycle completion
module mem_port_arbiter #(
    parameter int LINE_W       = mem_port_arbiter_pkg::LINE_W,
    parameter int DC_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic [31:0]       ic_miss_addr,
    output logic              ic_miss_ack,
    output logic [LINE_W-1:0] ic_data_fill,
    input  logic              dc_miss,
    input  logic [31:0]       dc_miss_addr,
    input  logic              dc_evict,
    input  logic [31:0]       dc_evict_addr,
    input  logic [LINE_W-1:0] dc_evict_data,
    output logic              dc_miss_ack,
    output logic [LINE_W-1:0] dc_data_fill,
    input  logic              io_access,
    input  logic              io_rw,
    input  logic [31:0]       io_addr,
    input  logic [31:0]       io_wr_data,
    output logic              io_ack,
    output logic [31:0]       io_rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_io,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    import mem_port_arbiter_pkg::*;

    localparam int CNT_W = $clog2(DC_BURST_MAX + 1);

    arb_state_t         state, state_next;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_next;
    logic               burst_sat;
    logic               bus_done;
    logic [NUM_REQ-1:0] grant;

    logic              mem_req_next, mem_we_next, mem_io_next;
    logic [31:0]       mem_addr_next;
    logic [LINE_W-1:0] mem_wdata_next;
    logic              ic_miss_ack_next, dc_miss_ack_next, io_ack_next;
    logic [LINE_W-1:0] ic_data_fill_next, dc_data_fill_next;
    logic [31:0]       io_rd_data_next;

    assign burst_sat = (burst_cnt == CNT_W'(DC_BURST_MAX));

    // A bus acknowledge only counts while our own request is outstanding.
    assign bus_done = mem_req & mem_ack;

    mem_port_prio_sel u_prio_sel (
        .dc_req    (dc_miss),
        .io_req    (io_access),
        .ic_req    (ic_miss),
        .burst_sat (burst_sat),
        .grant     (grant)
    );

    // State, starvation counter and every externally visible output are
    // registered here so the bus and the caches only ever see flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_io       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            ic_miss_ack  <= 1'b0;
            dc_miss_ack  <= 1'b0;
            io_ack       <= 1'b0;
            ic_data_fill <= '0;
            dc_data_fill <= '0;
            io_rd_data   <= '0;
        end else begin
            state        <= state_next;
            burst_cnt    <= burst_cnt_next;
            mem_req      <= mem_req_next;
            mem_we       <= mem_we_next;
            mem_io       <= mem_io_next;
            mem_addr     <= mem_addr_next;
            mem_wdata    <= mem_wdata_next;
            ic_miss_ack  <= ic_miss_ack_next;
            dc_miss_ack  <= dc_miss_ack_next;
            io_ack       <= io_ack_next;
            ic_data_fill <= ic_data_fill_next;
            dc_data_fill <= dc_data_fill_next;
            io_rd_data   <= io_rd_data_next;
        end
    end

    // Sequencing: a grant taken in IDLE runs one bus transaction (two for a
    // dirty miss), then a single RELEASE cycle lets the requester drop its
    // level before IDLE looks at the requests again.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant[REQ_DC]) begin
                    state_next = dc_evict ? EVICT : DC_FILL;
                end else if (grant[REQ_IO]) begin
                    state_next = IO_XFER;
                end else if (grant[REQ_IC]) begin
                    state_next = IC_FILL;
                end
            end
            EVICT:   if (bus_done) state_next = DC_FILL;
            DC_FILL: if (bus_done) state_next = RELEASE;
            IO_XFER: if (bus_done) state_next = RELEASE;
            IC_FILL: if (bus_done) state_next = RELEASE;
            default: state_next = IDLE;
        endcase
    end

    // Burst counter: counts D-side grants made while the I-cache is waiting,
    // saturating at the limit. It resets when the I-cache is served or when
    // the I-cache is not asking at all.
    always_comb begin
        burst_cnt_next = burst_cnt;
        if (state == IDLE) begin
            if (grant[REQ_IC]) begin
                burst_cnt_next = '0;
            end else if (!ic_miss) begin
                burst_cnt_next = '0;
            end else if ((grant[REQ_DC] || grant[REQ_IO]) && !burst_sat) begin
                burst_cnt_next = burst_cnt + CNT_W'(1);
            end
        end
    end

    // Output next-values. Bus fields are loaded only when a request starts so
    // they stay stable for its whole duration. After an evict completes, the
    // request drops for one cycle and the fill is issued as a separate bus
    // request from DC_FILL. Acks are single-cycle pulses with their data.
    always_comb begin
        mem_req_next      = mem_req;
        mem_we_next       = mem_we;
        mem_io_next       = mem_io;
        mem_addr_next     = mem_addr;
        mem_wdata_next    = mem_wdata;
        ic_miss_ack_next  = 1'b0;
        dc_miss_ack_next  = 1'b0;
        io_ack_next       = 1'b0;
        ic_data_fill_next = ic_data_fill;
        dc_data_fill_next = dc_data_fill;
        io_rd_data_next   = io_rd_data;
        case (state)
            IDLE: begin
                if (grant[REQ_DC]) begin
                    mem_req_next = 1'b1;
                    mem_io_next  = 1'b0;
                    if (dc_evict) begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = dc_evict_addr;
                        mem_wdata_next = dc_evict_data;
                    end else begin
                        mem_we_next    = 1'b0;
                        mem_addr_next  = dc_miss_addr;
                        mem_wdata_next = '0;
                    end
                end else if (grant[REQ_IO]) begin
                    mem_req_next   = 1'b1;
                    mem_io_next    = 1'b1;
                    mem_we_next    = io_rw;
                    mem_addr_next  = io_addr;
                    mem_wdata_next = {{(LINE_W-32){1'b0}}, io_wr_data};
                end else if (grant[REQ_IC]) begin
                    mem_req_next   = 1'b1;
                    mem_io_next    = 1'b0;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = ic_miss_addr;
                    mem_wdata_next = '0;
                end
            end
            EVICT: begin
                if (bus_done) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                end
            end
            DC_FILL: begin
                if (bus_done) begin
                    mem_req_next      = 1'b0;
                    dc_miss_ack_next  = 1'b1;
                    dc_data_fill_next = mem_rdata;
                end else if (!mem_req) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_io_next    = 1'b0;
                    mem_addr_next  = dc_miss_addr;
                    mem_wdata_next = '0;
                end
            end
            IO_XFER: begin
                if (bus_done) begin
                    mem_req_next    = 1'b0;
                    mem_we_next     = 1'b0;
                    mem_io_next     = 1'b0;
                    io_ack_next     = 1'b1;
                    io_rd_data_next = mem_we ? 32'd0 : mem_rdata[31:0];
                end
            end
            IC_FILL: begin
                if (bus_done) begin
                    mem_req_next      = 1'b0;
                    ic_miss_ack_next  = 1'b1;
                    ic_data_fill_next = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ic_miss = 1'b0;
    logic [31:0]  ic_miss_addr = '0;
    logic         ic_miss_ack;
    logic [127:0] ic_data_fill;
    logic         dc_miss = 1'b0;
    logic [31:0]  dc_miss_addr = '0;
    logic         dc_evict = 1'b0;
    logic [31:0]  dc_evict_addr = '0;
    logic [127:0] dc_evict_data = '0;
    logic         dc_miss_ack;
    logic [127:0] dc_data_fill;
    logic         io_access = 1'b0;
    logic         io_rw = 1'b0;
    logic [31:0]  io_addr = '0;
    logic [31:0]  io_wr_data = '0;
    logic         io_ack;
    logic [31:0]  io_rd_data;
    logic         mem_req, mem_we, mem_io;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    // Bus responder settings and log of every bus request episode.
    int           ack_delay = 2;
    logic [127:0] bus_rdata = '0;
    int           resp_cnt = 0;
    logic         prev_req = 1'b0;
    int           cycle = 0;
    logic [31:0]  ep_addr[$];
    logic         ep_we[$];
    logic         ep_io[$];
    logic [127:0] ep_wdata[$];
    int           ep_cycle[$];

    mem_port_arbiter #(.LINE_W(128), .DC_BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .ic_miss_ack(ic_miss_ack), .ic_data_fill(ic_data_fill),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_evict(dc_evict), .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
        .dc_miss_ack(dc_miss_ack), .dc_data_fill(dc_data_fill),
        .io_access(io_access), .io_rw(io_rw), .io_addr(io_addr), .io_wr_data(io_wr_data),
        .io_ack(io_ack), .io_rd_data(io_rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Memory model: samples 2ns after each rising edge, logs new requests and
    // pulses mem_ack for one cycle ack_delay cycles after a request is seen.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cycle++;
            if (!rst_n) begin
                mem_ack = 1'b0;
                resp_cnt = 0;
                prev_req = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    ep_addr.push_back(mem_addr);
                    ep_we.push_back(mem_we);
                    ep_io.push_back(mem_io);
                    ep_wdata.push_back(mem_wdata);
                    ep_cycle.push_back(cycle);
                end
                prev_req = mem_req;
                if (mem_ack) begin
                    mem_ack = 1'b0;
                end else if (mem_req) begin
                    resp_cnt++;
                    if (resp_cnt >= ack_delay) begin
                        mem_ack = 1'b1;
                        mem_rdata = bus_rdata;
                        resp_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_io, ic_miss_ack, dc_miss_ack, io_ack} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {mem_req, mem_we, mem_io, ic_miss_ack, dc_miss_ack, io_ack});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 160'd0) begin
            failures++;
            $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({ic_data_fill, dc_data_fill, io_rd_data} !== 288'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got ic %h dc %h io %h expected 0",
                     ic_data_fill, dc_data_fill, io_rd_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.state !== IDLE || dut.burst_cnt !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got state %0d cnt %0d expected 0 0",
                     dut.state, dut.burst_cnt);
        end
    endtask

    task automatic test_clean_miss();
        int ep0, lat, stray;
        logic seen;
        logic [127:0] fill;
        ep0 = ep_addr.size();
        ack_delay = 2;
        bus_rdata = {16{8'hA5}};
        @(negedge clk);
        dc_miss_addr = 32'h0000_1230;
        dc_evict = 1'b0;
        dc_miss = 1'b1;
        lat = 0; stray = 0; seen = 1'b0; fill = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (io_ack || ic_miss_ack) stray++;
            if (dc_miss_ack) begin
                seen = 1'b1;
                fill = dc_data_fill;
                dc_miss = 1'b0;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_ack_seen: got %b expected 1", seen);
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("[TB] FAIL clean_latency: got %0d expected 3", lat);
        end
        checks++;
        if (fill !== {16{8'hA5}}) begin
            failures++;
            $display("[TB] FAIL clean_fill: got %h expected %h", fill, {16{8'hA5}});
        end
        checks++;
        if (ep_addr.size() - ep0 != 1) begin
            failures++;
            $display("[TB] FAIL clean_episodes: got %0d expected 1", ep_addr.size() - ep0);
        end else begin
            checks++;
            if ({ep_addr[ep0], ep_we[ep0], ep_io[ep0]} !== {32'h0000_1230, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL clean_bus: got addr %h we %b io %b expected 00001230 0 0",
                         ep_addr[ep0], ep_we[ep0], ep_io[ep0]);
            end
        end
        @(negedge clk);
        checks++;
        if (dc_miss_ack !== 1'b0 || stray != 0) begin
            failures++;
            $display("[TB] FAIL clean_pulse: got ack %b stray %0d expected 0 0", dc_miss_ack, stray);
        end
    endtask

    task automatic test_dirty_miss();
        int ep0, acks;
        logic [127:0] fill;
        ep0 = ep_addr.size();
        ack_delay = 1;
        bus_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        @(negedge clk);
        dc_evict_addr = 32'h0000_0450;
        dc_evict_data = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
        dc_miss_addr = 32'h0000_7450;
        dc_evict = 1'b1;
        dc_miss = 1'b1;
        acks = 0; fill = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dc_miss_ack) begin
                acks++;
                fill = dc_data_fill;
                dc_miss = 1'b0;
                dc_evict = 1'b0;
            end
            if (acks != 0 && i > 30) break;
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("[TB] FAIL dirty_ack_count: got %0d expected 1", acks);
        end
        checks++;
        if (fill !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
            failures++;
            $display("[TB] FAIL dirty_fill: got %h", fill);
        end
        checks++;
        if (ep_addr.size() - ep0 != 2) begin
            failures++;
            $display("[TB] FAIL dirty_episodes: got %0d expected 2", ep_addr.size() - ep0);
        end else begin
            checks++;
            if ({ep_addr[ep0], ep_we[ep0], ep_wdata[ep0]} !==
                {32'h0000_0450, 1'b1, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555}) begin
                failures++;
                $display("[TB] FAIL dirty_evict: got addr %h we %b wdata %h",
                         ep_addr[ep0], ep_we[ep0], ep_wdata[ep0]);
            end
            checks++;
            if ({ep_addr[ep0+1], ep_we[ep0+1]} !== {32'h0000_7450, 1'b0}) begin
                failures++;
                $display("[TB] FAIL dirty_fill_req: got addr %h we %b expected 00007450 0",
                         ep_addr[ep0+1], ep_we[ep0+1]);
            end
        end
    endtask

    task automatic test_io();
        int ep0;
        logic seen;
        logic [31:0] rd;
        ep0 = ep_addr.size();
        ack_delay = 2;
        bus_rdata = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h1234_5678};
        @(negedge clk);
        io_rw = 1'b0;
        io_addr = 32'h0000_FF04;
        io_access = 1'b1;
        seen = 1'b0; rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (io_ack) begin seen = 1'b1; rd = io_rd_data; io_access = 1'b0; break; end
        end
        checks++;
        if (seen !== 1'b1 || rd !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL io_read: got ack %b data %h expected 1 12345678", seen, rd);
        end
        repeat (2) @(negedge clk);
        io_rw = 1'b1;
        io_wr_data = 32'hDEAD_BEEF;
        io_access = 1'b1;
        seen = 1'b0; rd = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (io_ack) begin seen = 1'b1; rd = io_rd_data; io_access = 1'b0; break; end
        end
        checks++;
        if (seen !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("[TB] FAIL io_write_ack: got ack %b data %h expected 1 00000000", seen, rd);
        end
        checks++;
        if (ep_addr.size() - ep0 != 2) begin
            failures++;
            $display("[TB] FAIL io_episodes: got %0d expected 2", ep_addr.size() - ep0);
        end else begin
            checks++;
            if ({ep_io[ep0], ep_we[ep0], ep_addr[ep0]} !== {1'b1, 1'b0, 32'h0000_FF04}) begin
                failures++;
                $display("[TB] FAIL io_read_bus: got io %b we %b addr %h expected 1 0 0000ff04",
                         ep_io[ep0], ep_we[ep0], ep_addr[ep0]);
            end
            checks++;
            if ({ep_io[ep0+1], ep_we[ep0+1], ep_wdata[ep0+1]} !== {1'b1, 1'b1, 96'd0, 32'hDEAD_BEEF}) begin
                failures++;
                $display("[TB] FAIL io_write_bus: got io %b we %b wdata %h",
                         ep_io[ep0+1], ep_we[ep0+1], ep_wdata[ep0+1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int ep0, multi;
        int order[$];
        ep0 = ep_addr.size();
        ack_delay = 1;
        bus_rdata = 128'h5;
        multi = 0;
        @(negedge clk);
        dc_miss_addr = 32'h0000_2000; dc_evict = 1'b0;
        io_addr = 32'h0000_3004; io_rw = 1'b0;
        ic_miss_addr = 32'h0000_4000;
        dc_miss = 1'b1; io_access = 1'b1; ic_miss = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (int'(dc_miss_ack) + int'(io_ack) + int'(ic_miss_ack) > 1) multi++;
            if (dc_miss_ack) begin order.push_back(REQ_DC); dc_miss = 1'b0; end
            if (io_ack) begin order.push_back(REQ_IO); io_access = 1'b0; end
            if (ic_miss_ack) begin order.push_back(REQ_IC); ic_miss = 1'b0; end
            if (!dc_miss && !io_access && !ic_miss) break;
        end
        dc_miss = 1'b0; io_access = 1'b0; ic_miss = 1'b0;
        checks++;
        if (order.size() != 3 || multi != 0) begin
            failures++;
            $display("[TB] FAIL simul_acks: got %0d acks %0d overlaps expected 3 0", order.size(), multi);
        end else begin
            checks++;
            if (order[0] != REQ_DC || order[1] != REQ_IO || order[2] != REQ_IC) begin
                failures++;
                $display("[TB] FAIL simul_order: got %0d %0d %0d expected 0 1 2",
                         order[0], order[1], order[2]);
            end
        end
        checks++;
        if (ep_addr.size() - ep0 != 3) begin
            failures++;
            $display("[TB] FAIL simul_episodes: got %0d expected 3", ep_addr.size() - ep0);
        end else begin
            checks++;
            if (ep_cycle[ep0+1] - ep_cycle[ep0] != 3 || ep_cycle[ep0+2] - ep_cycle[ep0+1] != 3) begin
                failures++;
                $display("[TB] FAIL simul_spacing: got %0d %0d expected 3 3",
                         ep_cycle[ep0+1] - ep_cycle[ep0], ep_cycle[ep0+2] - ep_cycle[ep0+1]);
            end
            checks++;
            if (ep_addr[ep0+2] !== 32'h0000_4000 || ep_io[ep0+1] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL simul_bus: got ic addr %h io flag %b expected 00004000 1",
                         ep_addr[ep0+2], ep_io[ep0+1]);
            end
        end
    endtask

    task automatic test_starvation();
        int dc_acks, dc_at_ic;
        logic rearm, ic_done;
        logic [127:0] fill;
        ack_delay = 1;
        bus_rdata = 128'h7777_0000_0000_0000_0000_0000_0000_1234;
        @(negedge clk);
        checks++;
        if (dut.burst_cnt !== 3'd0) begin
            failures++;
            $display("[TB] FAIL starve_cnt_start: got %0d expected 0", dut.burst_cnt);
        end
        ic_miss_addr = 32'h0000_5000;
        dc_miss_addr = 32'h0000_6000;
        dc_evict = 1'b0;
        ic_miss = 1'b1;
        dc_miss = 1'b1;
        dc_acks = 0; dc_at_ic = -1; rearm = 1'b0; ic_done = 1'b0; fill = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ic_miss_ack) begin
                ic_done = 1'b1;
                dc_at_ic = dc_acks;
                fill = ic_data_fill;
                break;
            end
            if (dc_miss_ack) begin
                dc_acks++;
                dc_miss = 1'b0;
                rearm = 1'b1;
            end else if (rearm) begin
                dc_miss = 1'b1;
                rearm = 1'b0;
            end
        end
        ic_miss = 1'b0;
        dc_miss = 1'b0;
        checks++;
        if (ic_done !== 1'b1 || dc_at_ic != 4) begin
            failures++;
            $display("[TB] FAIL starve_guard: got ic_ack %b after %0d dc acks expected 1 after 4",
                     ic_done, dc_at_ic);
        end
        checks++;
        if (fill !== 128'h7777_0000_0000_0000_0000_0000_0000_1234) begin
            failures++;
            $display("[TB] FAIL starve_ic_fill: got %h", fill);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dut.burst_cnt !== 3'd0 || dut.state !== IDLE) begin
            failures++;
            $display("[TB] FAIL starve_cnt_end: got cnt %0d state %0d expected 0 0",
                     dut.burst_cnt, dut.state);
        end
    endtask

    task automatic test_reset_mid_evict();
        logic busy;
        int acks;
        ack_delay = 20;
        @(negedge clk);
        dc_evict_addr = 32'h0000_0880;
        dc_evict_data = 128'h1;
        dc_miss_addr = 32'h0000_9880;
        dc_evict = 1'b1;
        dc_miss = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) begin busy = 1'b1; break; end
        end
        checks++;
        if (busy !== 1'b1 || dut.state !== EVICT) begin
            failures++;
            $display("[TB] FAIL rst_evict_busy: got req %b state %0d expected 1 1", busy, dut.state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_io, dc_miss_ack, io_ack, ic_miss_ack} !== 6'b0 ||
            mem_addr !== 32'd0 || mem_wdata !== 128'd0) begin
            failures++;
            $display("[TB] FAIL rst_async: got req %b we %b addr %h wdata %h expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        dc_miss = 1'b0;
        dc_evict = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dc_miss_ack || io_ack || ic_miss_ack || mem_req) acks++;
        end
        checks++;
        if (acks != 0 || dut.state !== IDLE) begin
            failures++;
            $display("[TB] FAIL rst_no_stale: got activity %0d state %0d expected 0 0", acks, dut.state);
        end
        ack_delay = 2;
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_io();
        test_simultaneous();
        test_starvation();
        test_reset_mid_evict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
